// File: rtl/dmac_req_scheduler.sv
// DMAC request scheduler: round-robin arbitration of peripheral requests,
// system-bus acquisition, single-transfer launch/tracking on the channel
// engine, and sticky per-channel done/error status driving the interrupt.
module dmac_req_scheduler #(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] DmacReq,
  input  logic [NUM_CH-1:0] Ch_En,
  output logic [NUM_CH-1:0] ReqAck,
  output logic              Bus_Req,
  input  logic              Bus_Grant,
  output logic              Xfer_Start,
  output logic [CH_W-1:0]   Xfer_Ch,
  output logic              Xfer_Hold,
  input  logic              Xfer_Done,
  input  logic              Xfer_Err,
  input  logic [NUM_CH-1:0] Irq_Clr,
  output logic [NUM_CH-1:0] Done_Status,
  output logic [NUM_CH-1:0] Err_Status,
  output logic              Interrupt,
  output logic              Busy
);

  typedef enum logic [2:0] {IDLE, REQ_BUS, START, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   rr_reg, rr_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic              err_flag_reg, err_flag_next;
  logic [NUM_CH-1:0] ack_reg, ack_next;
  logic              bus_req_reg, start_reg, busy_reg;
  logic [NUM_CH-1:0] done_reg, done_next, done_set;
  logic [NUM_CH-1:0] err_reg, err_next, err_set;
  logic [NUM_CH-1:0] elig;
  logic [CH_W-1:0]   win_idx;
  logic              win_found;

  // A channel holding an unserviced status bit is skipped until software clears it.
  assign elig = DmacReq & Ch_En & ~done_reg & ~err_reg;

  // Round-robin pick: first eligible channel at or above the pointer, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_reg) + k) % NUM_CH;
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = CH_W'(idx);
      end
    end
  end

  // Next-state logic plus the per-transfer side effects (ack, status set, pointer).
  always_comb begin
    state_next    = state_reg;
    ch_next       = ch_reg;
    rr_next       = rr_reg;
    err_flag_next = err_flag_reg;
    ack_next      = '0;
    done_set      = '0;
    err_set       = '0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          ch_next           = win_idx;
          ack_next[win_idx] = 1'b1;
          state_next        = REQ_BUS;
        end
      end
      REQ_BUS: begin
        if (Bus_Grant) state_next = START;
      end
      START: begin
        state_next = RUN;
      end
      RUN: begin
        // Completion is accepted regardless of grant; error dominates done.
        if (Xfer_Err || Xfer_Done) begin
          err_flag_next = Xfer_Err;
          state_next    = DONE;
        end
      end
      DONE: begin
        if (err_flag_reg) err_set[ch_reg]  = 1'b1;
        else              done_set[ch_reg] = 1'b1;
        rr_next    = (ch_reg == CH_W'(NUM_CH - 1)) ? '0 : ch_reg + CH_W'(1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status update per bit: a set in the same cycle as a clear takes priority.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_status
    assign done_next[gi] = done_set[gi] | (done_reg[gi] & ~Irq_Clr[gi]);
    assign err_next[gi]  = err_set[gi]  | (err_reg[gi]  & ~Irq_Clr[gi]);
  end

  // State register and registered outputs, derived from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      rr_reg       <= '0;
      ch_reg       <= '0;
      err_flag_reg <= 1'b0;
      ack_reg      <= '0;
      bus_req_reg  <= 1'b0;
      start_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= '0;
      err_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      rr_reg       <= rr_next;
      ch_reg       <= ch_next;
      err_flag_reg <= err_flag_next;
      ack_reg      <= ack_next;
      bus_req_reg  <= (state_next == REQ_BUS) || (state_next == START) || (state_next == RUN);
      start_reg    <= (state_next == START);
      busy_reg     <= (state_next != IDLE);
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign ReqAck      = ack_reg;
  assign Bus_Req     = bus_req_reg;
  assign Xfer_Start  = start_reg;
  assign Xfer_Ch     = ch_reg;
  assign Busy        = busy_reg;
  assign Done_Status = done_reg;
  assign Err_Status  = err_reg;
  // Engine stalls only while a running transfer has lost the bus.
  assign Xfer_Hold   = (state_reg == RUN) && !Bus_Grant;
  assign Interrupt   = |(done_reg | err_reg);

endmodule
